// File: rtl/io_link_pkg.sv
// Shared types for the SW->HW link receiver: phase codes on the PIO pair and
// handshake FSM states.
package io_link_pkg;

    typedef enum logic [1:0] {
        SIG_IDLE = 2'd0,
        SIG_A    = 2'd1,
        SIG_B    = 2'd2,
        SIG_EOF  = 2'd3
    } sig_t;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WAIT_SPACE,
        ST_ACK
    } state_t;

    // EOF as the remembered phase makes an empty frame right after reset a duplicate.
    localparam sig_t RESET_LAST_PHASE = SIG_EOF;

endpackage

// File: rtl/io_link_fifo.sv
// First-word-fall-through FIFO with occupancy count; the head is presented
// combinationally and reads as zero while empty.
module io_link_fifo #(
    parameter int WIDTH = 10,
    parameter int DEPTH = 16
) (
    input  logic                     clk50,
    input  logic                     reset,
    input  logic                     push,
    input  logic [WIDTH-1:0]         push_data,
    input  logic                     pop,
    output logic [WIDTH-1:0]         head,
    output logic                     valid,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL = (AW+1)'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             pop_eff;
    logic             push_eff;

    assign valid    = (count != '0);
    assign pop_eff  = pop & valid;
    // A push while full is accepted only when the head leaves in the same cycle.
    assign push_eff = push & ((count != FULL) | pop_eff);
    assign head     = valid ? mem[rd_ptr] : '0;

    // NOTE: state registers use non-blocking assignments so every flop samples
    // pre-edge values regardless of statement order.
    always_ff @(posedge clk50) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_eff) wr_ptr <= wr_ptr + AW'(1);
            if (pop_eff)  rd_ptr <= rd_ptr + AW'(1);
            case ({push_eff, pop_eff})
                2'b10:   count <= count + (AW+1)'(1);
                2'b01:   count <= count - (AW+1)'(1);
                default: count <= count;
            endcase
        end
    end

    // NOTE: storage is deliberately not reset; validity is tracked by count,
    // and leaving the array reset-free lets it map onto RAM.
    always_ff @(posedge clk50) begin
        if (push_eff) mem[wr_ptr] <= push_data;
    end

endmodule

// File: rtl/io_link_rx.sv
// Four-phase SW->HW word receiver: synchronises the PIO phase code, drops
// retransmitted duplicates, tags frame ends and buffers words for a stream sink.
module io_link_rx
    import io_link_pkg::*;
#(
    parameter int DATA_W = 9,
    parameter int DEPTH  = 16,
    parameter int CNT_W  = 8
) (
    input  logic                    clk50,
    input  logic                    reset,
    input  logic [DATA_W-1:0]       to_hw_data,
    input  logic [1:0]              to_hw_sig,
    output logic [1:0]              to_sw_sig,
    output logic [DATA_W-1:0]       out_data,
    output logic                    out_last,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [$clog2(DEPTH):0]  fifo_count,
    output logic [CNT_W-1:0]        dup_count
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FIFO_FULL = (AW+1)'(DEPTH);

    state_t            state;
    sig_t              last_phase;
    logic [1:0]        sig_s1;
    logic [1:0]        sig_s;
    logic [1:0]        code_q;
    logic [DATA_W-1:0] data_q;
    logic              pop;
    logic              space;
    logic              push;
    logic [DATA_W:0]   push_word;
    logic [DATA_W:0]   head;

    assign pop   = out_valid & out_ready;
    assign space = (fifo_count != FIFO_FULL) | pop;

    // NOTE: every output of this block gets a default first, so no path can
    // leave it unassigned and infer a latch.
    always_comb begin
        push      = 1'b0;
        push_word = {sig_s == SIG_EOF, to_hw_data};
        case (state)
            ST_IDLE: begin
                if (sig_s != SIG_IDLE && sig_s != last_phase && space) push = 1'b1;
            end
            ST_WAIT_SPACE: begin
                push_word = {code_q == SIG_EOF, data_q};
                if (sig_s != SIG_IDLE && space) push = 1'b1;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk50) begin
        if (reset) begin
            sig_s1     <= '0;
            sig_s      <= '0;
            state      <= ST_IDLE;
            to_sw_sig  <= '0;
            last_phase <= RESET_LAST_PHASE;
            dup_count  <= '0;
            code_q     <= '0;
            data_q     <= '0;
        end else begin
            sig_s1 <= to_hw_sig;
            sig_s  <= sig_s1;
            case (state)
                ST_IDLE: begin
                    if (sig_s != SIG_IDLE) begin
                        code_q <= sig_s;
                        data_q <= to_hw_data;
                        if (sig_s == last_phase) begin
                            if (dup_count != {CNT_W{1'b1}}) dup_count <= dup_count + CNT_W'(1);
                            to_sw_sig <= sig_s;
                            state     <= ST_ACK;
                        end else if (space) begin
                            last_phase <= sig_t'(sig_s);
                            to_sw_sig  <= sig_s;
                            state      <= ST_ACK;
                        end else begin
                            state <= ST_WAIT_SPACE;
                        end
                    end
                end
                ST_WAIT_SPACE: begin
                    // A withdrawn request wins over space appearing in the same cycle.
                    if (sig_s == SIG_IDLE) begin
                        state <= ST_IDLE;
                    end else if (space) begin
                        last_phase <= sig_t'(code_q);
                        to_sw_sig  <= code_q;
                        state      <= ST_ACK;
                    end
                end
                ST_ACK: begin
                    if (sig_s == SIG_IDLE) begin
                        to_sw_sig <= '0;
                        state     <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    io_link_fifo #(
        .WIDTH (DATA_W + 1),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk50     (clk50),
        .reset     (reset),
        .push      (push),
        .push_data (push_word),
        .pop       (pop),
        .head      (head),
        .valid     (out_valid),
        .count     (fifo_count)
    );

    assign out_data = head[DATA_W-1:0];
    assign out_last = head[DATA_W];

endmodule

// File: tb/tb_io_link_rx.sv
// Scoreboard bench for io_link_rx: stimulus queues expected words, a negedge
// monitor compares every word the DUT hands over on the stream port.
module tb_io_link_rx;
    localparam int DATA_W = 9;
    localparam int DEPTH  = 4;
    localparam int CNT_W  = 8;
    localparam int AW     = $clog2(DEPTH);

    logic              clk50 = 1'b0;
    logic              reset;
    logic [DATA_W-1:0] to_hw_data;
    logic [1:0]        to_hw_sig;
    logic [1:0]        to_sw_sig;
    logic [DATA_W-1:0] out_data;
    logic              out_last;
    logic              out_valid;
    logic              out_ready;
    logic [AW:0]       fifo_count;
    logic [CNT_W-1:0]  dup_count;

    int checks   = 0;
    int failures = 0;
    logic [DATA_W:0] exp_q [$];
    logic [DATA_W:0] mon_exp;

    io_link_rx #(.DATA_W(DATA_W), .DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
        .clk50      (clk50),
        .reset      (reset),
        .to_hw_data (to_hw_data),
        .to_hw_sig  (to_hw_sig),
        .to_sw_sig  (to_sw_sig),
        .out_data   (out_data),
        .out_last   (out_last),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .fifo_count (fifo_count),
        .dup_count  (dup_count)
    );

    always #10 clk50 = ~clk50;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk50);
        #1;
    endtask

    // Monitor: a pop happens at the next rising edge whenever valid & ready here.
    always @(negedge clk50) begin
        if (reset === 1'b0 && out_valid === 1'b1 && out_ready === 1'b1) begin
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL sb_unexpected: got 0x%0h expected no word at %0t",
                         {out_last, out_data}, $time);
            end else begin
                mon_exp = exp_q.pop_front();
                check("sb_word", {22'd0, out_last, out_data}, {22'd0, mon_exp});
            end
        end
    end

    task automatic apply_reset();
        reset = 1'b1;
        exp_q.delete();
        tick();
        check("rst_to_sw_sig",  to_sw_sig,  0);
        check("rst_fifo_count", fifo_count, 0);
        check("rst_out_valid",  out_valid,  0);
        check("rst_out_last",   out_last,   0);
        check("rst_out_data",   out_data,   0);
        check("rst_dup_count",  dup_count,  0);
        reset = 1'b0;
    endtask

    // Full four-phase exchange with ack latency checks on both edges.
    task automatic handshake(input logic [1:0] code, input logic [DATA_W-1:0] data, input bit fresh);
        to_hw_sig  = code;
        to_hw_data = data;
        if (fresh) exp_q.push_back({code == 2'd3, data});
        tick(); tick();
        check("ack_early", to_sw_sig, 0);
        tick();
        check("ack_rise", to_sw_sig, code);
        to_hw_sig = 2'd0;
        tick(); tick();
        check("ack_hold", to_sw_sig, code);
        tick();
        check("ack_fall", to_sw_sig, 0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset      = 1'b1;
        to_hw_sig  = 2'd0;
        to_hw_data = '0;
        out_ready  = 1'b1;
        tick();

        // Basic alternating phases
        apply_reset();
        handshake(2'd1, 9'h0A1, 1'b1);
        handshake(2'd2, 9'h0A2, 1'b1);
        check("basic_dup", dup_count, 0);

        // Retransmitted phase is acked but dropped
        apply_reset();
        handshake(2'd1, 9'h011, 1'b1);
        handshake(2'd1, 9'h022, 1'b0);
        check("dup_count_1", dup_count, 1);

        // Frame end tagging and empty-frame rejection
        apply_reset();
        handshake(2'd1, 9'h001, 1'b1);
        handshake(2'd2, 9'h002, 1'b1);
        handshake(2'd3, 9'h003, 1'b1);
        handshake(2'd3, 9'h004, 1'b0);
        check("eof_dup_count", dup_count, 1);

        // Backpressure: fill, stall fifth word, release with one pop
        apply_reset();
        out_ready = 1'b0;
        handshake(2'd1, 9'h101, 1'b1);
        handshake(2'd2, 9'h102, 1'b1);
        handshake(2'd1, 9'h103, 1'b1);
        handshake(2'd2, 9'h104, 1'b1);
        check("bp_full_count", fifo_count, 4);
        check("bp_full_valid", out_valid, 1);
        to_hw_sig  = 2'd1;
        to_hw_data = 9'h105;
        repeat (6) tick();
        check("bp_stall_ack", to_sw_sig, 0);
        check("bp_stall_count", fifo_count, 4);
        exp_q.push_back({1'b0, 9'h105});
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check("bp_pushpop_count", fifo_count, 4);
        check("bp_late_ack", to_sw_sig, 1);
        to_hw_sig = 2'd0;
        repeat (3) tick();
        check("bp_ack_fall", to_sw_sig, 0);

        // Abort while full: no push, no ack, remembered phase unchanged
        to_hw_sig  = 2'd2;
        to_hw_data = 9'h1AB;
        for (int i = 0; i < 6; i++) begin
            tick();
            check("abort_ack_raised", to_sw_sig, 0);
        end
        to_hw_sig = 2'd0;
        for (int i = 0; i < 4; i++) begin
            tick();
            check("abort_ack_dropped", to_sw_sig, 0);
        end
        check("abort_count", fifo_count, 4);
        out_ready = 1'b1;
        repeat (6) tick();
        check("abort_drained", fifo_count, 0);
        handshake(2'd1, 9'h1B1, 1'b0);
        check("abort_keeps_phase", dup_count, 1);

        // Reset during ACK with three words held, level still raised
        apply_reset();
        out_ready = 1'b0;
        handshake(2'd1, 9'h0C1, 1'b1);
        handshake(2'd1, 9'h0C9, 1'b0);
        handshake(2'd2, 9'h0C2, 1'b1);
        to_hw_sig  = 2'd1;
        to_hw_data = 9'h0C3;
        exp_q.push_back({1'b0, 9'h0C3});
        repeat (3) tick();
        check("mid_ack", to_sw_sig, 1);
        check("mid_count", fifo_count, 3);
        check("mid_dup", dup_count, 1);
        apply_reset();
        exp_q.push_back({1'b0, 9'h0C3});
        tick(); tick();
        check("post_rst_ack_early", to_sw_sig, 0);
        tick();
        check("post_rst_ack", to_sw_sig, 1);
        check("post_rst_count", fifo_count, 1);
        repeat (5) tick();
        check("post_rst_once", fifo_count, 1);
        check("post_rst_ack_hold", to_sw_sig, 1);
        to_hw_sig = 2'd0;
        repeat (3) tick();
        check("post_rst_ack_fall", to_sw_sig, 0);
        out_ready = 1'b1;
        repeat (3) tick();
        check("final_count", fifo_count, 0);
        check("sb_empty", exp_q.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
